// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch controller: debounced start/stop and lap/reset buttons drive a
// 4-digit BCD hundredths counter with a lap snapshot for the 7-segment stage.
module bcd_stopwatch_ctrl #(
    parameter int TICK_DIV  = 500000,
    parameter int DB_CYCLES = 500000
) (
    input  logic        clock_50Mhz,
    input  logic        reset,
    input  logic        btn_start_stop,
    input  logic        btn_lap_reset,
    output logic [15:0] bcd_out,
    output logic        running,
    output logic        lap_active,
    output logic        wrap
);

    localparam int PW = (TICK_DIV  > 2) ? $clog2(TICK_DIV)  : 1;
    localparam int DW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE
    } state_t;

    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {btn_lap_reset, btn_start_stop};

    // Index 0 is start/stop, index 1 is lap/reset.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic          sync1_reg;
            logic          sync2_reg;
            logic          db_state_reg;
            logic          db_prev_reg;
            logic [DW-1:0] db_cnt_reg;

            always_ff @(posedge clock_50Mhz or negedge reset) begin
                if (!reset) begin
                    sync1_reg    <= 1'b1;
                    sync2_reg    <= 1'b1;
                    db_state_reg <= 1'b1;
                    db_prev_reg  <= 1'b1;
                    db_cnt_reg   <= '0;
                end else begin
                    sync1_reg   <= btn_raw[gi];
                    sync2_reg   <= sync1_reg;
                    db_prev_reg <= db_state_reg;
                    if (sync2_reg == db_state_reg) begin
                        db_cnt_reg <= '0;
                    end else if (db_cnt_reg == DW'(DB_CYCLES - 1)) begin
                        db_state_reg <= sync2_reg;
                        db_cnt_reg   <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + DW'(1);
                    end
                end
            end

            assign press[gi] = db_prev_reg & ~db_state_reg;
        end
    endgenerate

    state_t        state_reg;
    logic [PW-1:0] presc_reg;
    logic [15:0]   count_reg;
    logic [15:0]   count_next;
    logic [15:0]   snap_reg;
    logic          lap_reg;
    logic          running_reg;
    logic          wrap_reg;
    logic          tick;

    assign tick = (state_reg == ST_RUN) && (presc_reg == PW'(TICK_DIV - 1));

    // Ripple the tick through the digits; a carry only survives a digit at 9.
    always_comb begin
        logic carry;
        count_next = count_reg;
        carry      = tick;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (count_reg[4*i +: 4] == 4'd9) begin
                    count_next[4*i +: 4] = 4'd0;
                end else begin
                    count_next[4*i +: 4] = count_reg[4*i +: 4] + 4'd1;
                    carry                = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock_50Mhz or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            presc_reg   <= '0;
            count_reg   <= '0;
            snap_reg    <= '0;
            lap_reg     <= 1'b0;
            running_reg <= 1'b0;
            wrap_reg    <= 1'b0;
        end else begin
            wrap_reg <= tick && (count_reg == 16'h9999);

            // The tick is judged on the current state, so it still lands on a RUN->PAUSE edge.
            if (state_reg == ST_RUN) begin
                presc_reg <= tick ? '0 : presc_reg + PW'(1);
                count_reg <= count_next;
            end

            if (press[0]) begin
                case (state_reg)
                    ST_IDLE: begin
                        state_reg   <= ST_RUN;
                        running_reg <= 1'b1;
                        presc_reg   <= '0;
                    end
                    ST_RUN: begin
                        state_reg   <= ST_PAUSE;
                        running_reg <= 1'b0;
                    end
                    ST_PAUSE: begin
                        state_reg   <= ST_RUN;
                        running_reg <= 1'b1;
                    end
                    default: begin
                        state_reg   <= ST_IDLE;
                        running_reg <= 1'b0;
                    end
                endcase
            end else if (press[1]) begin
                case (state_reg)
                    ST_RUN: begin
                        lap_reg <= ~lap_reg;
                        if (!lap_reg) begin
                            snap_reg <= count_reg;
                        end
                    end
                    ST_PAUSE: begin
                        count_reg <= '0;
                        snap_reg  <= '0;
                        lap_reg   <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                    default: begin
                        lap_reg <= lap_reg;
                    end
                endcase
            end
        end
    end

    assign bcd_out    = lap_reg ? snap_reg : count_reg;
    assign running    = running_reg;
    assign lap_active = lap_reg;
    assign wrap       = wrap_reg;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl: directed scenarios plus random button chatter,
// compared every cycle against an arithmetic model of elapsed run time.
module tb_bcd_stopwatch_ctrl;

    localparam int TICK_DIV  = 2;
    localparam int DB_CYCLES = 3;
    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_PAUSE   = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        bss;
    logic        blr;
    logic [15:0] bcd;
    logic        running;
    logic        lap_active;
    logic        wrap;

    int checks   = 0;
    int failures = 0;

    // Model: elapsed RUN cycles since the last entry to IDLE define the count.
    int                     rc;
    int                     mstate;
    bit                     mlap;
    int                     msnap;
    bit                     mwrap;
    bit                     acc_ss, acc_lr;
    bit                     pend_ss, pend_lr;
    logic [DB_CYCLES+1:0]   h_ss, h_lr;

    bcd_stopwatch_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clock_50Mhz    (clk),
        .reset          (reset_n),
        .btn_start_stop (bss),
        .btn_lap_reset  (blr),
        .bcd_out        (bcd),
        .running        (running),
        .lap_active     (lap_active),
        .wrap           (wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        r[15:12] = 4'((n / 1000) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[3:0]   = 4'(n % 10);
        return r;
    endfunction

    function automatic int mcount();
        return (rc / TICK_DIV) % 10000;
    endfunction

    function automatic logic [15:0] exp_bcd();
        return mlap ? to_bcd(msnap) : to_bcd(mcount());
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        rc      = 0;
        mstate  = M_IDLE;
        mlap    = 1'b0;
        msnap   = 0;
        mwrap   = 1'b0;
        acc_ss  = 1'b1;
        acc_lr  = 1'b1;
        pend_ss = 1'b0;
        pend_lr = 1'b0;
        h_ss    = '1;
        h_lr    = '1;
    endtask

    // A level is accepted once the last DB_CYCLES synchronized samples all disagree with it.
    task automatic db_model(input bit raw, inout logic [DB_CYCLES+1:0] h, inout bit acc, output bit fell);
        h    = {h[DB_CYCLES:0], raw};
        fell = 1'b0;
        if (h[DB_CYCLES+1:2] == {DB_CYCLES{~acc}}) begin
            fell = acc;
            acc  = ~acc;
        end
    endtask

    task automatic model_update();
        int cb;
        cb    = mcount();
        mwrap = 1'b0;
        if (mstate == M_RUN) begin
            rc++;
            if (rc % (TICK_DIV * 10000) == 0) mwrap = 1'b1;
        end
        if (pend_ss) begin
            if (mstate == M_IDLE) begin
                mstate = M_RUN;
                rc     = 0;
            end else if (mstate == M_RUN) begin
                mstate = M_PAUSE;
            end else begin
                mstate = M_RUN;
            end
        end else if (pend_lr) begin
            if (mstate == M_RUN) begin
                if (!mlap) msnap = cb;
                mlap = ~mlap;
            end else if (mstate == M_PAUSE) begin
                rc     = 0;
                msnap  = 0;
                mlap   = 1'b0;
                mstate = M_IDLE;
            end
        end
        db_model(bss, h_ss, acc_ss, pend_ss);
        db_model(blr, h_lr, acc_lr, pend_lr);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("bcd_out", bcd, exp_bcd());
        check("running", {15'd0, running}, {15'd0, mstate == M_RUN});
        check("lap_active", {15'd0, lap_active}, {15'd0, mlap});
        check("wrap", {15'd0, wrap}, {15'd0, mwrap});
    endtask

    task automatic press(input bit do_ss, input bit do_lr, input int low_cycles);
        $display("press start_stop=%0d lap_reset=%0d low=%0d t=%0t", do_ss, do_lr, low_cycles, $time);
        if (do_ss) bss = 1'b0;
        if (do_lr) blr = 1'b0;
        repeat (low_cycles) step();
        bss = 1'b1;
        blr = 1'b1;
    endtask

    task automatic run_until_count(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (mcount() != target && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            checks++;
            failures++;
            $display("FAIL %s timeout observed=%h expected=%h", tag, bcd, to_bcd(target));
        end
        check(tag, bcd, to_bcd(target));
    endtask

    task automatic run_until_rc(input int target, input string tag);
        int n;
        n = 0;
        while (rc + 5 != target && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL %s timeout observed_rc=%0d expected_rc=%0d", tag, rc + 5, target);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_bcd"}, bcd, 16'h0000);
        check({tag, "_running"}, {15'd0, running}, 16'h0000);
        check({tag, "_lap"}, {15'd0, lap_active}, 16'h0000);
        check({tag, "_wrap"}, {15'd0, wrap}, 16'h0000);
    endtask

    initial begin
        int frozen;
        int n;
        reset_n = 1'b0;
        bss     = 1'b1;
        blr     = 1'b1;
        model_reset();
        #12;
        check_zero("reset");
        reset_n = 1'b1;
        repeat (100) step();
        check("idle_bcd", bcd, 16'h0000);

        // Short glitch is rejected, a 3-cycle hold starts the run at edge k+5.
        press(1'b1, 1'b0, 2);
        repeat (10) step();
        check("glitch_running", {15'd0, running}, 16'h0000);
        press(1'b1, 1'b0, 3);
        step();
        step();
        check("db_early", {15'd0, running}, 16'h0000);
        step();
        check("db_edge", {15'd0, running}, 16'h0001);

        run_until_count(12, 100, "count12");
        check("run12_running", {15'd0, running}, 16'h0001);
        press(1'b1, 1'b0, 3);
        repeat (3) step();
        check("paused", {15'd0, running}, 16'h0000);
        frozen = mcount();
        repeat (10) step();
        check("frozen", bcd, to_bcd(frozen));
        press(1'b1, 1'b0, 3);
        repeat (3) step();
        check("resumed", {15'd0, running}, 16'h0001);
        run_until_count(frozen + 8, 100, "resume8");

        // Pause then lap clears back to IDLE.
        repeat (6) step();
        press(1'b1, 1'b0, 3);
        repeat (3) step();
        check("pause2", {15'd0, running}, 16'h0000);
        repeat (6) step();
        press(1'b0, 1'b1, 3);
        repeat (3) step();
        check_zero("clear");

        // Simultaneous presses from IDLE: start wins, lap is dropped.
        repeat (6) step();
        press(1'b1, 1'b1, 3);
        repeat (3) step();
        check("prio_running", {15'd0, running}, 16'h0001);
        check("prio_lap", {15'd0, lap_active}, 16'h0000);
        repeat (5) step();
        check("prio_lap_late", {15'd0, lap_active}, 16'h0000);

        // Lap capture at 0015, release at internal 0030.
        repeat (4) step();
        run_until_rc(30, "lap_on_align");
        press(1'b0, 1'b1, 3);
        repeat (3) step();
        check("lap_on_bcd", bcd, 16'h0015);
        check("lap_on_flag", {15'd0, lap_active}, 16'h0001);
        repeat (10) step();
        check("lap_hold", bcd, 16'h0015);
        run_until_rc(60, "lap_off_align");
        press(1'b0, 1'b1, 3);
        repeat (3) step();
        check("lap_off_bcd", bcd, 16'h0030);
        check("lap_off_flag", {15'd0, lap_active}, 16'h0000);

        // Rollover 9999 -> 0000 with a single-cycle wrap pulse.
        run_until_count(9999, 25000, "reach9999");
        n = 0;
        while (!mwrap && n < 4) begin
            step();
            n++;
        end
        check("wrap_bcd", bcd, 16'h0000);
        check("wrap_pulse", {15'd0, wrap}, 16'h0001);
        step();
        check("wrap_drop", {15'd0, wrap}, 16'h0000);
        run_until_count(1, 4, "after_wrap");

        // Asynchronous reset mid-run.
        repeat (3) step();
        reset_n = 1'b0;
        #1;
        check_zero("midrun_reset");
        model_reset();
        #1;
        reset_n = 1'b1;
        repeat (100) step();
        check("post_reset_bcd", bcd, 16'h0000);

        // Random chatter on both buttons.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(3) == 0) bss = ~bss;
            if ($urandom_range(4) == 0) blr = ~blr;
            step();
        end
        bss = 1'b1;
        blr = 1'b1;
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
